// File: rtl/led_ctrl_pkg.sv
// Shared types and helpers for the LED pattern sequencer.
// Modes, run/pause state and the per-mode pattern seed.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        ROT_L  = 2'd0,
        ROT_R  = 2'd1,
        BOUNCE = 2'd2,
        BLINK  = 2'd3
    } mode_e;

    typedef enum logic {
        RUN    = 1'b0,
        PAUSED = 1'b1
    } state_e;

    localparam int unsigned LED_MAX = 32;

    // Seed is 1 for the one-hot modes and n ones for BLINK (n <= LED_MAX).
    function automatic logic [LED_MAX-1:0] seed_for(
        input mode_e       m,
        input int unsigned n
    );
        logic [LED_MAX-1:0] s;
        if (m == BLINK) begin
            s = '1;
            s = s >> (LED_MAX - n);
        end else begin
            s = LED_MAX'(1);
        end
        return s;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Step-rate prescaler: counts 0..TICK_DIV-1 while enabled.
// tick is combinational on the terminal count with en high.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 12000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          at_last;

    always_comb begin
        at_last = (cnt_q == LAST);
        tick    = en && at_last;
        cnt_d   = cnt_q;
        if (en) begin
            cnt_d = at_last ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_pattern_ctrl.sv
// LED bank sequencer: prescaled stepping, mode handshake,
// pause and single-step control.
module led_pattern_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV = 12000000,
    parameter int unsigned N_LEDS   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode_i,
    input  logic              mode_valid_i,
    output logic              mode_ready_o,
    input  logic              pause_i,
    input  logic              step_i,
    output logic [N_LEDS-1:0] leds_o,
    output logic              tick_o,
    output logic [1:0]        mode_o
);

    state_e             state_q;
    state_e             state_d;
    logic               presc_en;
    logic               presc_tick;
    logic               step_ok;
    logic               step_edge;
    logic               xfer;
    logic               apply;

    mode_e              mode_q;
    mode_e              mode_d;
    mode_e              pend_mode_q;
    mode_e              pend_mode_d;
    logic               pend_q;
    logic               pend_d;
    logic               ready_q;
    logic               ready_d;
    logic               dir_q;
    logic               dir_d;
    logic               tick_q;
    logic [N_LEDS-1:0]  leds_q;
    logic [N_LEDS-1:0]  leds_d;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_presc (
        .clk  (clk),
        .rst  (rst),
        .en   (presc_en),
        .tick (presc_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:    if (pause_i)  state_d = PAUSED;
            PAUSED: if (!pause_i) state_d = RUN;
        endcase
    end

    // pause_i gates the prescaler directly so a pause on the wrap edge wins
    always_comb begin
        presc_en = !pause_i;
        step_ok  = 1'b0;
        unique case (state_q)
            RUN:    step_ok = 1'b0;
            PAUSED: step_ok = step_i;
        endcase
    end

    assign step_edge = presc_tick | step_ok;
    assign xfer      = mode_valid_i & ready_q;
    assign apply     = step_edge & pend_q;

    always_comb begin
        pend_d      = pend_q;
        pend_mode_d = pend_mode_q;
        if (apply) begin
            pend_d = 1'b0;
        end
        if (xfer) begin
            pend_d      = 1'b1;
            pend_mode_d = mode_e'(mode_i);
        end
        ready_d = !pend_d;
    end

    // dir_q: 0 = moving towards MSB, 1 = moving towards bit0
    always_comb begin
        mode_d = mode_q;
        leds_d = leds_q;
        dir_d  = dir_q;
        if (apply) begin
            mode_d = pend_mode_q;
            leds_d = N_LEDS'(seed_for(pend_mode_q, N_LEDS));
            dir_d  = 1'b0;
        end else if (step_edge) begin
            unique case (mode_q)
                ROT_L: begin
                    leds_d = {leds_q[N_LEDS-2:0], leds_q[N_LEDS-1]};
                end
                ROT_R: begin
                    leds_d = {leds_q[0], leds_q[N_LEDS-1:1]};
                end
                BOUNCE: begin
                    if (!dir_q) begin
                        if (leds_q[N_LEDS-1]) begin
                            leds_d = leds_q >> 1;
                            dir_d  = 1'b1;
                        end else begin
                            leds_d = leds_q << 1;
                        end
                    end else begin
                        if (leds_q[0]) begin
                            leds_d = leds_q << 1;
                            dir_d  = 1'b0;
                        end else begin
                            leds_d = leds_q >> 1;
                        end
                    end
                end
                BLINK: begin
                    leds_d = ~leds_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q      <= ROT_L;
            pend_mode_q <= ROT_L;
            pend_q      <= 1'b0;
            ready_q     <= 1'b0;
            dir_q       <= 1'b0;
            tick_q      <= 1'b0;
            leds_q      <= N_LEDS'(1);
        end else begin
            mode_q      <= mode_d;
            pend_mode_q <= pend_mode_d;
            pend_q      <= pend_d;
            ready_q     <= ready_d;
            dir_q       <= dir_d;
            tick_q      <= step_edge;
            leds_q      <= leds_d;
        end
    end

    assign leds_o       = leds_q;
    assign tick_o       = tick_q;
    assign mode_o       = mode_q;
    assign mode_ready_o = ready_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Scoreboard bench for led_pattern_ctrl: directed scenarios then
// randomized traffic against a step-count reference model.
module tb_led_pattern_ctrl;

    localparam int TD = 4;
    localparam int NL = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    mode_i = 2'd0;
    logic          mode_valid_i = 1'b0;
    logic          mode_ready_o;
    logic          pause_i = 1'b0;
    logic          step_i = 1'b0;
    logic [NL-1:0] leds_o;
    logic          tick_o;
    logic [1:0]    mode_o;

    always #5 clk = ~clk;

    led_pattern_ctrl #(
        .TICK_DIV (TD),
        .N_LEDS   (NL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mode_i       (mode_i),
        .mode_valid_i (mode_valid_i),
        .mode_ready_o (mode_ready_o),
        .pause_i      (pause_i),
        .step_i       (step_i),
        .leds_o       (leds_o),
        .tick_o       (tick_o),
        .mode_o       (mode_o)
    );

    typedef struct packed {
        logic [NL-1:0] leds;
        logic [1:0]    mode;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;

    // Reference state: pattern is a pure function of mode and steps since seed
    int m_cnt = 0;
    bit m_paused = 0;
    bit m_ready = 0;
    bit m_pend = 0;
    int m_pmode = 0;
    int m_mode = 0;
    int m_k = 0;
    bit m_tick = 0;

    function automatic logic [NL-1:0] pat(input int md, input int k);
        int p;
        int per;
        case (md)
            0: return NL'(1 << (k % NL));
            1: return NL'(1 << ((NL - (k % NL)) % NL));
            2: begin
                per = 2 * (NL - 1);
                p = k % per;
                if (p >= NL) p = per - p;
                return NL'(1 << p);
            end
            default: return (k % 2 == 0) ? {NL{1'b1}} : '0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (tick_o === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected_tick: leds=%b at %0t", leds_o, $time);
            end else begin
                e = sbq.pop_front();
                chk("sb_leds", 32'(leds_o), 32'(e.leds));
                chk("sb_mode", 32'(mode_o), 32'(e.mode));
            end
        end
    end

    task automatic cyc(input bit r, input bit v, input int m,
                       input bit p, input bit s);
        bit   se;
        bit   xf;
        exp_t e;
        rst = r;
        mode_valid_i = v;
        mode_i = 2'(m);
        pause_i = p;
        step_i = s;
        if (r) begin
            m_cnt = 0;
            m_paused = 0;
            m_ready = 0;
            m_pend = 0;
            m_mode = 0;
            m_k = 0;
            m_tick = 0;
        end else begin
            se = (m_cnt == TD - 1 && !p) || (m_paused && s);
            xf = v && m_ready;
            if (!p) m_cnt = (m_cnt == TD - 1) ? 0 : m_cnt + 1;
            m_tick = se;
            if (se) begin
                if (m_pend) begin
                    m_mode = m_pmode;
                    m_k = 0;
                    m_pend = 0;
                end else begin
                    m_k++;
                end
                e.leds = pat(m_mode, m_k);
                e.mode = 2'(m_mode);
                sbq.push_back(e);
            end
            if (xf) begin
                m_pend = 1;
                m_pmode = m;
            end
            m_ready = !m_pend;
            m_paused = p;
        end
        @(posedge clk);
        #1;
        chk("leds", 32'(leds_o), 32'(pat(m_mode, m_k)));
        chk("mode", 32'(mode_o), 32'(m_mode));
        chk("tick", 32'(tick_o), 32'(m_tick));
        chk("ready", 32'(mode_ready_o), 32'(m_ready));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    task automatic req(input int m);
        cyc(0, 1, m, 0, 0);
    endtask

    task automatic wait_apply();
        for (int i = 0; i < 2 * TD && m_pend; i++) idle(1);
        chk("apply_bound", 32'(m_pend), 32'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rp;
        bit rs;
        bit rv;
        bit rr;
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        idle(12);
        idle(8);

        req(1);
        idle(12);
        cyc(1, 0, 0, 0, 0);
        req(1);
        idle(10);

        req(2);
        wait_apply();
        idle(8 * TD);

        req(3);
        cyc(0, 1, 3, 0, 0);
        cyc(0, 1, 3, 0, 0);
        wait_apply();
        idle(2 * TD);

        req(0);
        wait_apply();
        for (int i = 0; i < TD && m_cnt != 2; i++) idle(1);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        idle(6);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 1);

        for (int i = 0; i < TD && m_cnt != TD - 1; i++) idle(1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0);
        cyc(0, 1, 2, 1, 0);
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 1, 1);
        idle(2 * TD);

        req(2);
        wait_apply();
        idle(TD + 1);
        req(3);
        cyc(1, 0, 0, 0, 0);
        idle(3 * TD);
        req(2);
        idle(TD);
        cyc(0, 1, 3, 0, 0);
        idle(1);
        cyc(1, 0, 0, 0, 0);
        idle(3 * TD);

        rp = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(19) == 0) rp = !rp;
            rs = ($urandom_range(5) == 0);
            rv = ($urandom_range(4) == 0);
            rr = ($urandom_range(299) == 0);
            cyc(rr, rv, int'($urandom_range(3)), rp, rs);
        end

        idle(2);
        chk("sb_drained", 32'(sbq.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
